dc_sequencer: RTL and testbench
===============================

# dc_sequencer

Sequences the data-channel (DC) pointer datapath. It accepts one decoded DC command per handshake: advance read, advance write, or set forward/backward on one of four channels. It holds each channel's address pointer and direction, and performs the resulting memory access over a valid/ready request port with a response strobe. It sits between the DC decode logic and the core's data memory port, and stalls the core via `cmd_ready` while an access is outstanding.

## Interface
- `WORD_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, word-address width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when both high
- `advance_read`, `advance_write`, `set`, `set_direction`  in  1 each  decoded command fields
- `choice`  in  2  channel select
- `set_address`  in  ADDR_WIDTH  new pointer for `set`
- `write_value`  in  WORD_WIDTH  data for `advance_write`
- `read_valid`  out  1  one-cycle strobe, `read_value` valid
- `read_value`  out  WORD_WIDTH  registered read data
- `mem_req_valid`, `mem_req_we`  out  1  request strobe / write enable
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  ADDR_WIDTH; `mem_req_data`  out  WORD_WIDTH
- `mem_resp_valid`  in  1; `mem_resp_data`  in  WORD_WIDTH  read response

## Operation
- Per channel: `addr[c]` (ADDR_WIDTH), `dir[c]` (0 = +1, 1 = −1).
- Reset: all `addr` = 0, `dir` = 0, FSM = IDLE, `cmd_ready` = 1, `read_valid` = 0, `read_value` = 0, `mem_req_valid` = 0, `mem_req_we` = 0, `mem_req_addr` = 0, `mem_req_data` = 0.
- FSM states: IDLE, REQ, RESP, plus PF_REQ and PF_RESP when prefetch is enabled.
- `cmd_ready` = 1 only in IDLE.
- Command priority: `set` > `advance_read` > `advance_write`. A command with none of these fields asserted is accepted as a no-op.
- Set: loads `addr[c]` with `set_address` and `dir[c]` with `set_direction`. No memory access; FSM stays IDLE.
- Read: IDLE → REQ, presenting `addr[c]` with `we` = 0. REQ → RESP on `mem_req_ready`. RESP → IDLE on `mem_resp_valid`, latching data into `read_value`, pulsing `read_valid`, and stepping `addr[c]`.
- Write: IDLE → REQ with `we` = 1, `addr[c]`, and `write_value` latched into `mem_req_data`. REQ → IDLE on `mem_req_ready`; `addr[c]` steps. No response is expected.
- Step arithmetic: `addr ± 1` modulo 2^ADDR_WIDTH. 0 − 1 = all-ones; all-ones + 1 = 0.
- The request is held stable (valid, addr, data, we) until `mem_req_ready`.
- `mem_resp_valid` outside RESP/PF_RESP is ignored. This covers stale responses after reset.
- Reset mid-operation: the next edge returns to IDLE and clears all state; the pending access is abandoned.

## Timing
- Command accepted at edge T. Request is visible in cycle T+1.
- Read: response at edge R. `read_valid` is high and `addr` updated in cycle R+1; `cmd_ready` = 1 in R+1. Minimum latency: accept-to-`read_valid` is 3 cycles.
- Write: accepted by memory at edge A. `addr` updated and `cmd_ready` = 1 in cycle A+1.
- Set: takes effect at T+1. A back-to-back command is accepted at T+1.
- `mem_req_ready` and `mem_resp_valid` in the same cycle while in REQ: the response is ignored. Memory must respond no earlier than the cycle after acceptance.

## Configuration
- `DC_PREFETCH_EN` defined:
  - Adds one shared read-ahead buffer: `pf_valid`, `pf_chan`, `pf_data`.
  - After each completed read on channel c, the FSM goes RESP → PF_REQ and fetches the new `addr[c]`. Completion at PF_RESP fills the buffer, then the FSM returns to IDLE; `cmd_ready` = 0 throughout.
  - A read on channel c with `pf_valid && pf_chan == c` is a hit: `read_value` = `pf_data`, `read_valid` pulses, and `addr[c]` steps, all in cycle T+1. The FSM then enters PF_REQ for the next word.
  - Any set or write invalidates the buffer (`pf_valid` = 0).
  - Reset clears `pf_valid`.
- `DC_PREFETCH_EN` undefined: no buffer and no PF states; behaviour is exactly as in Operation.

## Structure
- Shared package `dc_pkg`: FSM state enum; `DC_CHANNELS` = 4; `DC_DIR_FWD` = 0 and `DC_DIR_BWD` = 1.
- One natural sub-module, `dc_pointer_file`: four `addr`/`dir` registers with a single set port and a single step port, plus asynchronous read by `choice`.

## Test plan
- Reset, then `set` ch2 with addr 0x100 and dir 0; two `advance_read` on ch2 with 1-cycle memory → requests at 0x100 and 0x101; `read_valid` returns memory data; `addr[2]` = 0x102.
- `set` ch1 with addr 0 and dir 1; `advance_write` of 0xDEADBEEF → write at 0x0; `addr[1]` = 0xFFFFFFFF (wrap).
- Hold `mem_req_ready` low 5 cycles during a write → `mem_req_valid`, `addr`, and `data` stay stable; `cmd_ready` = 0 until the cycle after acceptance.
- `set` and `advance_read` both high on ch0 → set only; no memory request.
- Assert `reset` while in RESP, then deliver `mem_resp_valid` → no `read_valid`; all outputs return to reset values.
- With `DC_PREFETCH_EN`: read ch3 at 0x40 → prefetch of 0x41 issued; next read ch3 gives `read_valid` at T+1 with no new request before the PF_REQ for 0x42. A write to ch3 in between forces a miss instead.

Source files
------------

// File: rtl/dc_pkg.sv
// Shared types and constants for the data-channel pointer sequencer.
package dc_pkg;

    localparam int unsigned DC_CHANNELS = 4;
    localparam int unsigned DC_CHAN_W   = 2;

    localparam logic DC_DIR_FWD = 1'b0;
    localparam logic DC_DIR_BWD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_RESP    = 3'd2
`ifdef DC_PREFETCH_EN
        ,
        ST_PF_REQ  = 3'd3,
        ST_PF_RESP = 3'd4
`endif
    } dc_state_e;

endpackage

// File: rtl/dc_pointer_file.sv
// Per-channel address pointers and directions: one set port, one step port,
// asynchronous read of the selected channel.
module dc_pointer_file
    import dc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_set_en,
    input  logic [DC_CHAN_W-1:0]  i_set_chan,
    input  logic [ADDR_WIDTH-1:0] i_set_addr,
    input  logic                  i_set_dir,
    input  logic                  i_step_en,
    input  logic [DC_CHAN_W-1:0]  i_step_chan,
    input  logic [DC_CHAN_W-1:0]  i_rd_chan,
    output logic [ADDR_WIDTH-1:0] o_rd_addr
);

    logic [ADDR_WIDTH-1:0]  r_addr [DC_CHANNELS];
    logic [DC_CHANNELS-1:0] r_dir;

    // Set wins over step; stepping wraps modulo 2^ADDR_WIDTH.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr <= '{default: '0};
            r_dir  <= {DC_CHANNELS{DC_DIR_FWD}};
        end else if (i_set_en) begin
            r_addr[i_set_chan] <= i_set_addr;
            r_dir[i_set_chan]  <= i_set_dir;
        end else if (i_step_en) begin
            r_addr[i_step_chan] <= (r_dir[i_step_chan] == DC_DIR_BWD)
                                   ? r_addr[i_step_chan] - ADDR_WIDTH'(1)
                                   : r_addr[i_step_chan] + ADDR_WIDTH'(1);
        end
    end

    assign o_rd_addr = r_addr[i_rd_chan];

endmodule

// File: rtl/dc_sequencer.sv
// Data-channel command sequencer driving a valid/ready memory port.
// Optional read-ahead buffer enabled by defining DC_PREFETCH_EN.
module dc_sequencer
    import dc_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_advance_read,
    input  logic                  i_advance_write,
    input  logic                  i_set,
    input  logic                  i_set_direction,
    input  logic [DC_CHAN_W-1:0]  i_choice,
    input  logic [ADDR_WIDTH-1:0] i_set_address,
    input  logic [WORD_WIDTH-1:0] i_write_value,
    output logic                  o_read_valid,
    output logic [WORD_WIDTH-1:0] o_read_value,
    output logic                  o_mem_req_valid,
    output logic                  o_mem_req_we,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    output logic [WORD_WIDTH-1:0] o_mem_req_data,
    input  logic                  i_mem_resp_valid,
    input  logic [WORD_WIDTH-1:0] i_mem_resp_data
);

    dc_state_e             r_state;
    logic [DC_CHAN_W-1:0]  r_chan;
    logic                  w_accept;
    logic                  w_set_en;
    logic                  w_step_en;
    logic [DC_CHAN_W-1:0]  w_step_chan;
    logic [DC_CHAN_W-1:0]  w_rd_chan;
    logic [ADDR_WIDTH-1:0] w_ptr_addr;
    logic                  w_pf_hit;

`ifdef DC_PREFETCH_EN
    logic                  r_pf_valid;
    logic [DC_CHAN_W-1:0]  r_pf_chan;
    logic [WORD_WIDTH-1:0] r_pf_data;

    assign w_pf_hit = w_accept && !i_set && i_advance_read
                      && r_pf_valid && (r_pf_chan == i_choice);
`else
    assign w_pf_hit = 1'b0;
`endif

    assign w_accept  = i_cmd_valid && o_cmd_ready;
    assign w_set_en  = w_accept && i_set;
    assign w_rd_chan = (r_state == ST_IDLE) ? i_choice : r_chan;

    // Pointer steps on write acceptance, read completion, or a prefetch hit.
    always_comb begin
        w_step_en   = 1'b0;
        w_step_chan = r_chan;
        case (r_state)
            ST_IDLE: begin
                w_step_en   = w_pf_hit;
                w_step_chan = i_choice;
            end
            ST_REQ:  w_step_en = o_mem_req_we && i_mem_req_ready;
            ST_RESP: w_step_en = i_mem_resp_valid;
            default: w_step_en = 1'b0;
        endcase
    end

    dc_pointer_file #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ptr (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_set_en    (w_set_en),
        .i_set_chan  (i_choice),
        .i_set_addr  (i_set_address),
        .i_set_dir   (i_set_direction),
        .i_step_en   (w_step_en),
        .i_step_chan (w_step_chan),
        .i_rd_chan   (w_rd_chan),
        .o_rd_addr   (w_ptr_addr)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_chan          <= '0;
            o_cmd_ready     <= 1'b1;
            o_read_valid    <= 1'b0;
            o_read_value    <= '0;
            o_mem_req_valid <= 1'b0;
            o_mem_req_we    <= 1'b0;
            o_mem_req_addr  <= '0;
            o_mem_req_data  <= '0;
`ifdef DC_PREFETCH_EN
            r_pf_valid      <= 1'b0;
            r_pf_chan       <= '0;
            r_pf_data       <= '0;
`endif
        end else begin
            o_read_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (i_set) begin
`ifdef DC_PREFETCH_EN
                            r_pf_valid <= 1'b0;
`endif
                        end else if (w_pf_hit) begin
`ifdef DC_PREFETCH_EN
                            o_read_value <= r_pf_data;
                            o_read_valid <= 1'b1;
                            r_pf_valid   <= 1'b0;
                            r_chan       <= i_choice;
                            o_cmd_ready  <= 1'b0;
                            r_state      <= ST_PF_REQ;
`endif
                        end else if (i_advance_read) begin
                            r_chan          <= i_choice;
                            o_mem_req_valid <= 1'b1;
                            o_mem_req_we    <= 1'b0;
                            o_mem_req_addr  <= w_ptr_addr;
                            o_cmd_ready     <= 1'b0;
                            r_state         <= ST_REQ;
                        end else if (i_advance_write) begin
                            r_chan          <= i_choice;
                            o_mem_req_valid <= 1'b1;
                            o_mem_req_we    <= 1'b1;
                            o_mem_req_addr  <= w_ptr_addr;
                            o_mem_req_data  <= i_write_value;
                            o_cmd_ready     <= 1'b0;
                            r_state         <= ST_REQ;
`ifdef DC_PREFETCH_EN
                            r_pf_valid      <= 1'b0;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        if (o_mem_req_we) begin
                            o_cmd_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (i_mem_resp_valid) begin
                        o_read_value <= i_mem_resp_data;
                        o_read_valid <= 1'b1;
`ifdef DC_PREFETCH_EN
                        r_state      <= ST_PF_REQ;
`else
                        o_cmd_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
`endif
                    end
                end
`ifdef DC_PREFETCH_EN
                // Issue one cycle after entry so the stepped pointer is visible.
                ST_PF_REQ: begin
                    if (!o_mem_req_valid) begin
                        o_mem_req_valid <= 1'b1;
                        o_mem_req_we    <= 1'b0;
                        o_mem_req_addr  <= w_ptr_addr;
                    end else if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        r_state         <= ST_PF_RESP;
                    end
                end
                ST_PF_RESP: begin
                    if (i_mem_resp_valid) begin
                        r_pf_valid  <= 1'b1;
                        r_pf_chan   <= r_chan;
                        r_pf_data   <= i_mem_resp_data;
                        o_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    o_mem_req_valid <= 1'b0;
                    o_cmd_ready     <= 1'b1;
                    r_state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dc_sequencer.sv
// Directed self-checking bench for dc_sequencer (prefetch scenario under DC_PREFETCH_EN).
module tb_dc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, adv_rd, adv_wr, set_f, set_dir;
    logic [1:0]  choice;
    logic [31:0] set_addr, wval, resp_data;
    logic        req_ready, resp_valid;
    logic        cmd_ready, read_valid, req_valid, req_we;
    logic [31:0] read_value, req_addr, req_data;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dc_sequencer #(.WORD_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_advance_read   (adv_rd),
        .i_advance_write  (adv_wr),
        .i_set            (set_f),
        .i_set_direction  (set_dir),
        .i_choice         (choice),
        .i_set_address    (set_addr),
        .i_write_value    (wval),
        .o_read_valid     (read_valid),
        .o_read_value     (read_value),
        .o_mem_req_valid  (req_valid),
        .o_mem_req_we     (req_we),
        .i_mem_req_ready  (req_ready),
        .o_mem_req_addr   (req_addr),
        .o_mem_req_data   (req_data),
        .i_mem_resp_valid (resp_valid),
        .i_mem_resp_data  (resp_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one command for exactly one accepting edge.
    task automatic send_cmd(input logic s, input logic r, input logic w, input logic [1:0] ch,
                            input logic d, input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        if (!cmd_ready) begin
            checks++;
            $display("FAIL cmd_ready_timeout: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; set_f = s; adv_rd = r; adv_wr = w;
        choice = ch; set_dir = d; set_addr = a; wval = v;
        tick();
        cmd_valid = 1'b0; set_f = 1'b0; adv_rd = 1'b0; adv_wr = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] ch, input logic [31:0] data, input int delay,
                           output logic rq_v, output logic [31:0] rq_a, output logic rq_we,
                           output logic rv, output logic [31:0] rval, output logic rdy);
        send_cmd(1'b0, 1'b1, 1'b0, ch, 1'b0, 32'h0, 32'h0);
        rq_v = req_valid; rq_a = req_addr; rq_we = req_we;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        repeat (delay) tick();
        resp_valid = 1'b1; resp_data = data; tick(); resp_valid = 1'b0;
        rv = read_valid; rval = read_value; rdy = cmd_ready;
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [31:0] v,
                            output logic rq_v, output logic [31:0] rq_a, output logic [31:0] rq_d,
                            output logic rq_we, output logic rdy);
        send_cmd(1'b0, 1'b0, 1'b1, ch, 1'b0, 32'h0, v);
        rq_v = req_valid; rq_a = req_addr; rq_d = req_data; rq_we = req_we;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        rdy = cmd_ready;
    endtask

    task automatic test_reset;
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); else passed++;
        checks++; if (read_valid !== 1'b0) $display("FAIL rst_read_valid: got %b want 0", read_valid); else passed++;
        checks++; if (read_value !== 32'h0) $display("FAIL rst_read_value: got %h want 0", read_value); else passed++;
        checks++; if (req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", req_valid); else passed++;
        checks++; if (req_we !== 1'b0) $display("FAIL rst_req_we: got %b want 0", req_we); else passed++;
        checks++; if (req_addr !== 32'h0) $display("FAIL rst_req_addr: got %h want 0", req_addr); else passed++;
        checks++; if (req_data !== 32'h0) $display("FAIL rst_req_data: got %h want 0", req_data); else passed++;
    endtask

    task automatic test_set_priority;
        logic v, we, rv, rdy; logic [31:0] a, rval;
        send_cmd(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h300, 32'h0);
        checks++; if (req_valid !== 1'b0) $display("FAIL prio_no_req: got %b want 0", req_valid); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL prio_ready: got %b want 1", cmd_ready); else passed++;
        tick();
        checks++; if (req_valid !== 1'b0) $display("FAIL prio_no_req_later: got %b want 0", req_valid); else passed++;
        do_read(2'd0, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'h300) $display("FAIL prio_addr: got %h want 300", a); else passed++;
    endtask

`ifndef DC_PREFETCH_EN
    task automatic test_set_read;
        logic v, we, rv, rdy; logic [31:0] a, rval;
        send_cmd(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        checks++; if ({cmd_ready, req_valid} !== 2'b10) $display("FAIL set_idle: got %b want 10", {cmd_ready, req_valid}); else passed++;
        do_read(2'd2, 32'hA5A5_0001, 0, v, a, we, rv, rval, rdy);
        checks++; if ({v, we} !== 2'b10) $display("FAIL rd1_req: got %b want 10", {v, we}); else passed++;
        checks++; if (a !== 32'h100) $display("FAIL rd1_addr: got %h want 100", a); else passed++;
        checks++; if (rv !== 1'b1) $display("FAIL rd1_valid: got %b want 1", rv); else passed++;
        checks++; if (rval !== 32'hA5A5_0001) $display("FAIL rd1_data: got %h want a5a50001", rval); else passed++;
        checks++; if (rdy !== 1'b1) $display("FAIL rd1_ready: got %b want 1", rdy); else passed++;
        tick();
        checks++; if (read_valid !== 1'b0) $display("FAIL rd1_strobe_len: got %b want 0", read_valid); else passed++;
        do_read(2'd2, 32'hA5A5_0002, 2, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'h101) $display("FAIL rd2_addr: got %h want 101", a); else passed++;
        checks++; if (rval !== 32'hA5A5_0002) $display("FAIL rd2_data: got %h want a5a50002", rval); else passed++;
        do_read(2'd2, 32'h3, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'h102) $display("FAIL rd3_addr: got %h want 102", a); else passed++;
    endtask

    task automatic test_write_wrap;
        logic v, we, rv, rdy; logic [31:0] a, d, rval;
        send_cmd(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
        do_write(2'd1, 32'hDEAD_BEEF, v, a, d, we, rdy);
        checks++; if ({v, we} !== 2'b11) $display("FAIL wr_req: got %b want 11", {v, we}); else passed++;
        checks++; if (a !== 32'h0) $display("FAIL wr_addr: got %h want 0", a); else passed++;
        checks++; if (d !== 32'hDEAD_BEEF) $display("FAIL wr_data: got %h want deadbeef", d); else passed++;
        checks++; if ({rdy, req_valid} !== 2'b10) $display("FAIL wr_done: got %b want 10", {rdy, req_valid}); else passed++;
        do_read(2'd1, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'hFFFF_FFFF) $display("FAIL bwd_wrap: got %h want ffffffff", a); else passed++;
        do_read(2'd1, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'hFFFF_FFFE) $display("FAIL bwd_step: got %h want fffffffe", a); else passed++;
        send_cmd(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 32'hFFFF_FFFF, 32'h0);
        do_read(2'd3, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'hFFFF_FFFF) $display("FAIL fwd_top: got %h want ffffffff", a); else passed++;
        do_read(2'd3, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'h0) $display("FAIL fwd_wrap: got %h want 0", a); else passed++;
    endtask

    task automatic test_write_stall;
        logic v, we, rv, rdy; logic [31:0] a, rval;
        logic [66:0] exp_busy;
        exp_busy = {1'b1, 1'b1, 1'b0, 32'h200, 32'h1234_5678};
        send_cmd(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h200, 32'h0);
        send_cmd(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({req_valid, req_we, cmd_ready, req_addr, req_data} !== exp_busy)
                $display("FAIL stall_hold[%0d]: got %h want %h", i,
                         {req_valid, req_we, cmd_ready, req_addr, req_data}, exp_busy);
            else passed++;
            tick();
        end
        req_ready = 1'b1;
        checks++; if ({req_valid, cmd_ready} !== 2'b10) $display("FAIL stall_accept: got %b want 10", {req_valid, cmd_ready}); else passed++;
        tick(); req_ready = 1'b0;
        checks++; if ({req_valid, cmd_ready} !== 2'b01) $display("FAIL stall_done: got %b want 01", {req_valid, cmd_ready}); else passed++;
        do_read(2'd0, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'h201) $display("FAIL stall_step: got %h want 201", a); else passed++;
    endtask

    task automatic test_back_to_back;
        logic v, we, rv, rdy; logic [31:0] a, rval;
        cmd_valid = 1'b1; set_f = 1'b1; choice = 2'd0; set_dir = 1'b0; set_addr = 32'h10;
        tick();
        checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", cmd_ready); else passed++;
        choice = 2'd1; set_dir = 1'b1; set_addr = 32'h20;
        tick();
        set_f = 1'b0;
        tick();
        cmd_valid = 1'b0;
        checks++; if ({cmd_ready, req_valid} !== 2'b10) $display("FAIL b2b_noop: got %b want 10", {cmd_ready, req_valid}); else passed++;
        do_read(2'd0, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'h10) $display("FAIL b2b_ch0: got %h want 10", a); else passed++;
        do_read(2'd1, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'h20) $display("FAIL b2b_ch1: got %h want 20", a); else passed++;
        do_read(2'd1, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'h1F) $display("FAIL b2b_ch1_bwd: got %h want 1f", a); else passed++;
    endtask

    task automatic test_reset_in_resp;
        logic v, we, rv, rdy; logic [31:0] a, rval;
        send_cmd(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
        send_cmd(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        checks++; if ({cmd_ready, req_valid} !== 2'b00) $display("FAIL rr_in_resp: got %b want 00", {cmd_ready, req_valid}); else passed++;
        reset = 1'b1; tick(); reset = 1'b0;
        resp_valid = 1'b1; resp_data = 32'hBAD0_BAD0; tick(); resp_valid = 1'b0;
        checks++; if (read_valid !== 1'b0) $display("FAIL rr_stale_valid: got %b want 0", read_valid); else passed++;
        checks++; if (read_value !== 32'h0) $display("FAIL rr_stale_value: got %h want 0", read_value); else passed++;
        checks++;
        if ({cmd_ready, req_valid, req_we, req_addr, req_data} !== {3'b100, 64'h0})
            $display("FAIL rr_outputs: got %h want %h", {cmd_ready, req_valid, req_we, req_addr, req_data}, {3'b100, 64'h0});
        else passed++;
        do_read(2'd2, 32'h0, 0, v, a, we, rv, rval, rdy);
        checks++; if (a !== 32'h0) $display("FAIL rr_ptr_cleared: got %h want 0", a); else passed++;
    endtask
`else
    task automatic test_prefetch;
        send_cmd(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
        send_cmd(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        checks++; if ({req_valid, req_addr} !== {1'b1, 32'h40}) $display("FAIL pf_rd_req: got %h want 140", {req_valid, req_addr}); else passed++;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        resp_valid = 1'b1; resp_data = 32'h1111_0040; tick(); resp_valid = 1'b0;
        checks++; if ({read_valid, cmd_ready, read_value} !== {2'b10, 32'h1111_0040}) $display("FAIL pf_rd_done: got %h", {read_valid, cmd_ready, read_value}); else passed++;
        tick();
        checks++; if ({req_valid, req_we, req_addr} !== {2'b10, 32'h41}) $display("FAIL pf_req_41: got %h", {req_valid, req_we, req_addr}); else passed++;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        resp_valid = 1'b1; resp_data = 32'h1111_0041; tick(); resp_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL pf_fill_ready: got %b want 1", cmd_ready); else passed++;
        send_cmd(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        checks++; if ({read_valid, req_valid, read_value} !== {2'b10, 32'h1111_0041}) $display("FAIL pf_hit: got %h", {read_valid, req_valid, read_value}); else passed++;
        tick();
        checks++; if ({req_valid, req_addr} !== {1'b1, 32'h42}) $display("FAIL pf_req_42: got %h want 142", {req_valid, req_addr}); else passed++;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        resp_valid = 1'b1; resp_data = 32'h1111_0042; tick(); resp_valid = 1'b0;
        send_cmd(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h77);
        checks++; if ({req_valid, req_we, req_addr} !== {2'b11, 32'h42}) $display("FAIL pf_wr_req: got %h", {req_valid, req_we, req_addr}); else passed++;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        send_cmd(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        checks++; if ({read_valid, req_valid, req_addr} !== {2'b01, 32'h43}) $display("FAIL pf_miss: got %h", {read_valid, req_valid, req_addr}); else passed++;
    endtask
`endif

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; adv_rd = 1'b0; adv_wr = 1'b0; set_f = 1'b0;
        set_dir = 1'b0; choice = 2'd0; set_addr = 32'h0; wval = 32'h0;
        resp_data = 32'h0; req_ready = 1'b0; resp_valid = 1'b0;
        test_reset();
        test_set_priority();
`ifndef DC_PREFETCH_EN
        test_set_read();
        test_write_wrap();
        test_write_stall();
        test_back_to_back();
        test_reset_in_resp();
`else
        test_prefetch();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
